// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with a writable control store and an instruction register
module micro_sequencer #(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           go_i,
  input  logic           stall_i,
  input  logic [AW-1:0]  address_i,
  input  logic [31:0]    instr_i,
  input  logic           cs_we_i,
  input  logic [AW-1:0]  cs_waddr_i,
  input  logic [AW+CW-1:0] cs_wdata_i,
  output logic [AW-1:0]  upc_o,
  output logic [AW-1:0]  branch_target_o,
  output logic [CW-1:0]  ctrl_o,
  output logic [1:0]     op_o,
  output logic [5:0]     funct_o,
  output logic [3:0]     rd_o,
  output logic           running_o,
  output logic [15:0]    retired_o
);
  typedef enum logic {HALT, RUN} state_e;
  state_e            state_q;
  logic [AW-1:0]     upc_q, upc_d;
  logic [31:0]       ir_q;
  logic [15:0]       retired_q;
  logic [AW+CW-1:0]  cs_q [2**AW];
  logic              active, halt_req;
  always_comb begin
    active          = state_q == RUN && !stall_i;
    ctrl_o          = active ? cs_q[upc_q][CW-1:0] : '0;
    halt_req        = ctrl_o[CW-1];
    upc_d           = halt_req ? '0 : address_i;
    branch_target_o = cs_q[upc_q][AW+CW-1:CW];
    upc_o           = upc_q;
    op_o            = ir_q[27:26];
    funct_o         = ir_q[25:20];
    rd_o            = ir_q[15:12];
    running_o       = state_q == RUN;
    retired_o       = retired_q;
  end
  // the store itself is never cleared, so it survives reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= HALT;
      upc_q     <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else if (state_q == HALT) begin
      if (cs_we_i) cs_q[cs_waddr_i] <= cs_wdata_i;
      if (go_i) state_q <= RUN;
    end else if (!stall_i) begin
      upc_q <= upc_d;
      if (ctrl_o[0]) ir_q <= instr_i;
      if (upc_q != '0 && upc_d == '0) retired_q <= retired_q + 16'd1;
      if (halt_req) state_q <= HALT;
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: random and directed stimulus checked every cycle against a behavioural model
module tb_micro_sequencer;
  localparam int AW = 5;
  localparam int CW = 16;
  logic clk = 0;
  logic reset = 0, go = 0, stall = 0, cs_we = 0;
  logic [AW-1:0] address = 0, cs_waddr = 0;
  logic [31:0] instr = 0;
  logic [AW+CW-1:0] cs_wdata = 0;
  logic [AW-1:0] upc, branch_target;
  logic [CW-1:0] ctrl;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic running;
  logic [15:0] retired;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit follow = 0;

  micro_sequencer #(.AW(AW), .CW(CW)) dut (
    .clk_i(clk), .reset_i(reset), .go_i(go), .stall_i(stall), .address_i(address),
    .instr_i(instr), .cs_we_i(cs_we), .cs_waddr_i(cs_waddr), .cs_wdata_i(cs_wdata),
    .upc_o(upc), .branch_target_o(branch_target), .ctrl_o(ctrl), .op_o(op),
    .funct_o(funct), .rd_o(rd), .running_o(running), .retired_o(retired)
  );

  always #5 clk = ~clk;

  // behavioural model: plain integers and an array standing in for the store
  int unsigned m_mem [32];
  bit m_valid [32];
  bit m_run = 0;
  int m_upc = 0;
  int unsigned m_ir = 0;
  int m_ret = 0;

  always @(posedge clk) begin
    int unsigned word;
    int nxt;
    if (!reset) begin
      m_run = 0; m_upc = 0; m_ir = 0; m_ret = 0;
    end else if (!m_run) begin
      if (cs_we) begin
        m_mem[cs_waddr] = cs_wdata;
        m_valid[cs_waddr] = 1;
      end
      if (go) m_run = 1;
    end else if (!stall) begin
      word = m_mem[m_upc];
      nxt = ((word >> 15) & 1) != 0 ? 0 : int'(address);
      if ((word & 1) != 0) m_ir = instr;
      if (m_upc != 0 && nxt == 0) m_ret = (m_ret + 1) % 65536;
      if (((word >> 15) & 1) != 0) m_run = 0;
      m_upc = nxt;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("upc", upc, m_upc);
      chk("running", running, m_run);
      chk("retired", retired, m_ret);
      chk("op", op, (m_ir >> 26) & 3);
      chk("funct", funct, (m_ir >> 20) & 63);
      chk("rd", rd, (m_ir >> 12) & 15);
      if (m_valid[m_upc]) begin
        chk("branch_target", branch_target, (m_mem[m_upc] >> 16) & 31);
        chk("ctrl", ctrl, (m_run && !stall) ? (m_mem[m_upc] & 16'hFFFF) : 0);
      end else if (!m_run) chk("ctrl_halt", ctrl, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (follow) address = AW'((m_mem[m_upc] >> 16) & 31);
  endtask

  task automatic wr(input int a, input int unsigned d);
    cs_we = 1; cs_waddr = AW'(a); cs_wdata = (AW+CW)'(d);
    tick();
    cs_we = 0;
  endtask

  task automatic settle_ctrl(input string name, input logic [CW-1:0] exp);
    #1;
    chk(name, ctrl, exp);
  endtask

  initial begin
    int r0;
    reset = 0; go = 1;
    tick(); tick();
    chk_en = 1;
    chk("rst_upc", upc, 0); chk("rst_ctrl", ctrl, 0); chk("rst_op", op, 0);
    chk("rst_funct", funct, 0); chk("rst_rd", rd, 0); chk("rst_retired", retired, 0);
    chk("rst_running", running, 0);
    reset = 1; go = 0;
    for (int i = 2; i < 32; i++) wr(i, $urandom);
    wr(0, {5'd1, 16'h0001});
    wr(1, {5'd0, 16'h0010});
    // two-state loop
    instr = 32'hE0811002;
    follow = 1;
    address = 5'd1;
    go = 1;
    tick();
    go = 0;
    chk("loop_run", running, 1); chk("loop_upc0", upc, 0); settle_ctrl("loop_ctrl0", 16'h0001);
    tick();
    chk("loop_upc1", upc, 1); chk("loop_op", op, 2'b00); chk("loop_funct", funct, 6'b001000);
    chk("loop_rd", rd, 4'b0001); settle_ctrl("loop_ctrl1", 16'h0010);
    tick();
    chk("loop_upc2", upc, 0); chk("loop_retired", retired, 1);
    tick();
    chk("loop_upc3", upc, 1);
    // stall at upc=1
    stall = 1; instr = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_upc", upc, 1); chk("stall_ctrl", ctrl, 0);
      chk("stall_funct", funct, 6'b001000); chk("stall_retired", retired, 1);
    end
    stall = 0; instr = 32'hE0811002;
    tick();
    chk("resume_upc", upc, 0); chk("resume_retired", retired, 2);
    // halt bit beats address
    reset = 0; tick(); reset = 1;
    wr(1, {5'd3, 16'h8000});
    go = 1; address = 5'd1; tick(); go = 0;
    tick();
    chk("halt_pre_upc", upc, 1); settle_ctrl("halt_ctrl", 16'h8000);
    tick();
    chk("halt_upc", upc, 0); chk("halt_running", running, 0); chk("halt_retired", retired, 1);
    go = 1; tick(); go = 0;
    chk("restart_run", running, 1); chk("restart_upc", upc, 0); settle_ctrl("restart_ctrl", 16'h0001);
    // write while running must be ignored
    cs_we = 1; cs_waddr = 0; cs_wdata = 21'h0FFFF;
    tick(); cs_we = 0;
    tick();
    chk("wrun_halted", running, 0);
    go = 1; tick(); go = 0;
    chk("wrun_upc", upc, 0); settle_ctrl("wrun_ctrl", 16'h0001);
    // reset mid-run
    tick(); tick();
    reset = 0; tick(); reset = 1;
    wr(1, {5'd0, 16'h0010});
    go = 1; tick(); go = 0;
    tick();
    chk("mid_pre_upc", upc, 1);
    reset = 0; tick(); reset = 1;
    chk("mid_upc", upc, 0); chk("mid_running", running, 0); chk("mid_op", op, 0);
    chk("mid_funct", funct, 0); chk("mid_rd", rd, 0); chk("mid_retired", retired, 0);
    go = 1; tick(); go = 0;
    chk("mid_restart_upc", upc, 0); settle_ctrl("mid_restart_ctrl", 16'h0001);
    // random traffic
    follow = 0;
    for (int i = 0; i < 2000; i++) begin
      r0 = int'($urandom_range(0, 99));
      reset = r0 != 0;
      go = $urandom_range(0, 1) == 1;
      stall = $urandom_range(0, 3) == 0;
      address = AW'($urandom);
      instr = $urandom;
      cs_we = $urandom_range(0, 2) == 0;
      cs_waddr = AW'($urandom);
      cs_wdata = (AW+CW)'($urandom);
      tick();
    end
    reset = 1; cs_we = 0; stall = 0; go = 0;
    tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer and control store for the multicycle control unit.
- Holds the micro-PC (uPC), the writable control store and the instruction register.
- Drives branch_target and the Op/Funct/Rd fields into the next-address dispatch stage.
- Registers that stage's address output as the next uPC and emits the per-cycle control word.

Parameters:
- AW, 5, uPC / control-store address width (store depth 2^AW).
- CW, 16, control word width; microword width = AW+CW.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- go  input  1  start request, sampled in HALT.
- stall  input  1  freeze sequencer for this cycle.
- address  input  AW  next uPC from the next-address dispatch stage.
- instr  input  32  fetched instruction word.
- cs_we  input  1  control-store write enable.
- cs_waddr  input  AW  control-store write address.
- cs_wdata  input  AW+CW  microword: [AW+CW-1:CW] = branch_target, [CW-1:0] = ctrl.
- upc  output  AW  current uPC.
- branch_target  output  AW  branch field of the current microword.
- ctrl  output  CW  control word of the current microword.
- Op  output  2  IR[27:26].
- Funct  output  6  IR[25:20].
- Rd  output  4  IR[15:12].
- running  output  1  1 in RUN, 0 in HALT.
- retired  output  16  count of completed macro-instructions.

Behaviour:
- Reset (reset=0 at an edge):
  - state <= HALT; upc, IR and retired <= 0.
  - Control-store contents are preserved.
  - Reset overrides every other input, including mid-run.
- Control store: 2^AW x (AW+CW) array, read combinationally at upc.
  - branch_target = cs[upc][AW+CW-1:CW], always driven, including in HALT.
  - ctrl[0] = IR write; ctrl[CW-1] = HALT request; all other bits pass through.
- Writes: at an edge with cs_we=1 while state=HALT, cs[cs_waddr] <= cs_wdata. The new value is visible on the outputs after that edge.
  - cs_we is ignored in RUN.
  - Unwritten entries are undefined; the bench loads every entry it uses.
- ctrl output gating: ctrl = cs[upc] ctrl field only when state=RUN and stall=0; otherwise ctrl = 0.
- HALT state:
  - upc held at 0; running = 0.
  - go=1 at an edge gives state <= RUN; upc stays 0, so the first RUN cycle executes cs[0].
- RUN state, edge with stall=0:
  - If ctrl[CW-1]=1: state <= HALT, upc <= 0, regardless of address.
  - Otherwise: upc <= address.
  - If ctrl[0]=1: IR <= instr. Op/Funct/Rd reflect the new IR the cycle after the load edge.
  - retired <= retired+1 when upc != 0 and the next upc is 0 (either address=0 or HALT). 16-bit counter, wraps 0xFFFF -> 0.
- RUN state, edge with stall=1:
  - upc, IR, state and retired are all held.
  - HALT and IR-write bits take no effect because ctrl is gated to 0.
- Latency: one cycle from address to upc; the microword follows upc combinationally.

Test Plan:
- Reset: hold reset=0 for 2 cycles with go=1 -> upc=0, ctrl=0, Op=0, Funct=0, Rd=0, retired=0, running=0.
- Two-state loop:
  - Load cs[0]={5'd1,16'h0001} and cs[1]={5'd0,16'h0010}; bench drives address=branch_target.
  - Apply go=1, then instr=32'hE0811002.
  - Required: upc sequence 0,1,0,1 with ctrl 0001,0010 alternating.
  - Required: after the first RUN edge, Op=2'b00, Funct=6'b001000, Rd=4'b0001.
  - Required: retired=1 after the first 1->0 transition.
- Stall: stall=1 for 3 cycles at upc=1 -> upc stays 1, ctrl=0, IR unchanged, retired unchanged; the loop resumes on stall=0.
- Halt:
  - Set cs[1]={5'd3,16'h8000} and run.
  - Required: after the upc=1 edge, upc=0 (not 3), running=0, retired incremented.
  - Required: go=1 one cycle later restarts at cs[0].
- Write in RUN: cs_we=1, cs_waddr=0, cs_wdata=21'h0FFFF while running -> ctrl at upc=0 is still 16'h0001.
- Reset mid-run: reset=0 at upc=1 -> next cycle upc=0, running=0, IR=0, retired=0. go=1 afterwards executes the original cs[0] (store preserved).
